// File: rtl/aes_prng_reseed_ctrl.sv
// aes_prng_reseed_ctrl
// Counts completed cipher blocks against the programmed PRNG reseed rate and
// raises a reseed request to the masking-PRNG/entropy interface when the
// limit is reached. While a reseed is pending, new block starts are held
// off. Software-forced reseeds and control-register commits are also handled.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   prng_reseed_rate_i  one-hot rate: 001 PER_1, 010 PER_64, 100 PER_8K
//   manual_operation_i  manual mode: completed blocks are not counted
//   ctrl_qe_i           control register committed, clears the block count
//   force_reseed_i      software-triggered reseed
//   start_i/start_gnt_o block start request and grant
//   block_done_i        one cipher block finished
//   reseed_req_o        reseed request, held until reseed_ack_i
//   block_cnt_o         blocks counted since the last reseed
//   err_o               sticky protocol error
module aes_prng_reseed_ctrl #(
  parameter int unsigned Per64Limit = 64,
  parameter int unsigned Per8kLimit = 8192,
  parameter int unsigned CntWidth   = 13
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [2:0]          prng_reseed_rate_i,
  input  logic                manual_operation_i,
  input  logic                ctrl_qe_i,
  input  logic                force_reseed_i,
  input  logic                start_i,
  output logic                start_gnt_o,
  input  logic                block_done_i,
  output logic                reseed_req_o,
  input  logic                reseed_ack_i,
  output logic [CntWidth-1:0] block_cnt_o,
  output logic                err_o
);

  // One extra bit so that a limit of 2**CntWidth is representable.
  localparam int unsigned LimW = CntWidth + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                busy_q;
  logic                err_q;

  logic [LimW-1:0]     limit;
  logic [LimW-1:0]     cnt_plus1;
  logic                limit_hit;

  // Rate decode; anything that is not a valid one-hot code falls back to PER_1.
  always_comb begin
    limit = LimW'(1);
    unique case (prng_reseed_rate_i)
      3'b010:  limit = LimW'(Per64Limit);
      3'b100:  limit = LimW'(Per8kLimit);
      default: limit = LimW'(1);
    endcase
  end

  assign cnt_plus1 = {1'b0, cnt_q} + LimW'(1);
  assign limit_hit = block_done_i && !manual_operation_i && (cnt_plus1 == limit);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A commit coinciding with a limit hit suppresses the
  // automatic request; a forced reseed still goes through.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (force_reseed_i || (limit_hit && !ctrl_qe_i)) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (reseed_ack_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    reseed_req_o = (state_q == REQ);
    start_gnt_o  = start_i && (state_q == IDLE);
  end

  // Block counter. It is cleared on every path into REQ, so it is already
  // zero while a request is pending; only a commit can touch it in REQ.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      if (ctrl_qe_i || force_reseed_i) begin
        cnt_d = '0;
      end else if (block_done_i && !manual_operation_i) begin
        cnt_d = limit_hit ? '0 : cnt_plus1[CntWidth-1:0];
      end
    end else if (ctrl_qe_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Outstanding-block flag: a grant in the same cycle as a completion means
  // a new block has begun, so the grant takes priority.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
    end else if (start_gnt_o) begin
      busy_q <= 1'b1;
    end else if (block_done_i) begin
      busy_q <= 1'b0;
    end
  end

  // Sticky error: completion without an outstanding block, or an ack while
  // no request is pending.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if ((block_done_i && !busy_q) || (reseed_ack_i && state_q == IDLE)) begin
      err_q <= 1'b1;
    end
  end

  assign block_cnt_o = cnt_q;
  assign err_o       = err_q;

endmodule
